// File: rtl/sinegen_ctrl.sv
// Sequencer for the dual-port sine ROM: phase accumulator, port-2 offset, burst/continuous playback.
// Build option: SINEGEN_CTRL_FRAC_PHASE_EN enables the 8.8 fractional phase accumulator.
module sinegen_ctrl #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic              dual,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic [ADDR_W+7:0] incr,
    input  logic [ADDR_W-1:0] offset,
    output logic              rom_en1,
    output logic              rom_en2,
    output logic [ADDR_W-1:0] rom_addr1,
    output logic [ADDR_W-1:0] rom_addr2,
    output logic              sample_valid,
    output logic              busy,
    output logic              done
);

`ifdef SINEGEN_CTRL_FRAC_PHASE_EN
    localparam int ACC_W = ADDR_W + 8;
`else
    localparam int ACC_W = ADDR_W;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q;
    logic              dual_q, dual_d;
    logic [CNT_W-1:0]  len_q;
    logic [ACC_W-1:0]  inc_q;
    logic [ACC_W-1:0]  inc_in;
    logic [ADDR_W-1:0] off_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              en1_q, en2_q, valid_q, done_q;
    logic              capture;
    logic              last;

`ifdef SINEGEN_CTRL_FRAC_PHASE_EN
    assign inc_in = incr;
`else
    // Without the fractional build only the integer step reaches the adder.
    logic unused_frac;
    assign unused_frac = ^incr[7:0];
    assign inc_in = incr[ADDR_W+7:8];
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    capture = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    if (mode && (burst_len == '0))
                        state_d = DRAIN;
                    else
                        state_d = RUN;
                end
            end
            RUN: begin
                last = mode_q && (cnt_q == len_q - CNT_W'(1));
                // Accumulator freezes on the way out so DRAIN holds the last address.
                if (stop || last)
                    state_d = DRAIN;
                else
                    acc_d = acc_q + inc_q;
                if (cnt_q != '1)
                    cnt_d = cnt_q + CNT_W'(1);
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dual_d = capture ? dual : dual_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            dual_q  <= 1'b0;
            len_q   <= '0;
            inc_q   <= '0;
            off_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                mode_q <= mode;
                dual_q <= dual;
                len_q  <= burst_len;
                inc_q  <= inc_in;
                off_q  <= offset;
            end
            en1_q   <= (state_d == RUN);
            en2_q   <= (state_d == RUN) && dual_d;
            valid_q <= en1_q;
            done_q  <= (state_q == DRAIN);
        end
    end

    assign rom_en1      = en1_q;
    assign rom_en2      = en2_q;
    assign rom_addr1    = acc_q[ACC_W-1 -: ADDR_W];
    assign rom_addr2    = rom_addr1 + off_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

endmodule

// File: tb/tb_sinegen_ctrl.sv
// Scoreboard bench for sinegen_ctrl: directed playback scenarios, monitor checks addresses/done timing.
module tb_sinegen_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic        dual = 1'b0;
    logic [15:0] burst_len = '0;
    logic [15:0] incr = '0;
    logic [7:0]  offset = '0;
    logic        rom_en1, rom_en2, sample_valid, busy, done;
    logic [7:0]  rom_addr1, rom_addr2;

    sinegen_ctrl #(.ADDR_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .mode(mode), .dual(dual), .burst_len(burst_len),
        .incr(incr), .offset(offset),
        .rom_en1(rom_en1), .rom_en2(rom_en2),
        .rom_addr1(rom_addr1), .rom_addr2(rom_addr2),
        .sample_valid(sample_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a1;
        logic [7:0] a2;
        logic       e2;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   vcnt = 0;
    logic prev_en1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input logic [7:0] a1, input logic [7:0] a2, input logic e2);
        exp_t e;
        e.a1 = a1;
        e.a2 = a2;
        e.e2 = e2;
        exp_q.push_back(e);
    endtask

    // Monitor: pops expected samples whenever a port-1 read is issued.
    always @(negedge clk) begin
        if (rst) begin
            prev_en1 = 1'b0;
        end else begin
            chk("valid_vs_prev_en", {31'd0, sample_valid}, {31'd0, prev_en1});
            prev_en1 = rom_en1;
            if (sample_valid) vcnt++;
            if (rom_en1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_en: addr1 %h, no sample expected", rom_addr1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("addr1", {24'd0, rom_addr1}, {24'd0, e.a1});
                    chk("addr2", {24'd0, rom_addr2}, {24'd0, e.a2});
                    chk("en2", {31'd0, rom_en2}, {31'd0, e.e2});
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    chk("done_cycle", cyc, done_q.pop_front());
                end
            end
        end
    end

    // Issues start; returns the cycle index N of the accepting edge.
    task automatic go(input logic m, input logic d, input logic [15:0] len,
                      input logic [15:0] inc, input logic [7:0] off, output int n);
        @(negedge clk);
        mode = m;
        dual = d;
        burst_len = len;
        incr = inc;
        offset = off;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = cyc;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int v0;
        logic [7:0] fr [5];

        #12;
        chk("reset_outputs", {24'd0, rom_en1, rom_en2, sample_valid, busy, done, 3'd0},
            32'd0);
        chk("reset_addrs", {16'd0, rom_addr1, rom_addr2}, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Burst, integer step, dual port
        for (int i = 0; i < 4; i++) push(8'(i), 8'(8'h40 + i), 1'b1);
        v0 = vcnt;
        go(1'b1, 1'b1, 16'd4, 16'h0100, 8'h40, n);
        done_q.push_back(n + 5);
        chk("burst_busy", {31'd0, busy}, 32'd1);
        chk("burst_first_valid", {31'd0, sample_valid}, 32'd0);
        idle(7);
        chk("burst_valids", vcnt - v0, 4);
        chk("burst_drained", exp_q.size(), 0);

        // Continuous wrap-around, stop in the fifth cycle
        push(8'h00, 8'hD0, 1'b1);
        push(8'h50, 8'h20, 1'b1);
        push(8'hA0, 8'h70, 1'b1);
        push(8'hF0, 8'hC0, 1'b1);
        push(8'h40, 8'h10, 1'b1);
        v0 = vcnt;
        go(1'b0, 1'b1, 16'd0, 16'h5000, 8'hD0, n);
        done_q.push_back(n + 6);
        idle(4);
        stop = 1'b1;
        idle(1);
        stop = 1'b0;
        idle(4);
        chk("wrap_valids", vcnt - v0, 5);
        chk("wrap_drained", exp_q.size(), 0);

        // Offset wrap: addr1 0x20 + 0xF0 = 0x10
        push(8'h00, 8'hF0, 1'b1);
        push(8'h20, 8'h10, 1'b1);
        go(1'b1, 1'b1, 16'd2, 16'h2000, 8'hF0, n);
        done_q.push_back(n + 3);
        idle(5);
        chk("offwrap_drained", exp_q.size(), 0);

        // Fractional step 0x0080
`ifdef SINEGEN_CTRL_FRAC_PHASE_EN
        fr[0] = 8'd0; fr[1] = 8'd0; fr[2] = 8'd1; fr[3] = 8'd1; fr[4] = 8'd2;
`else
        fr[0] = 8'd0; fr[1] = 8'd0; fr[2] = 8'd0; fr[3] = 8'd0; fr[4] = 8'd0;
`endif
        for (int i = 0; i < 5; i++) push(fr[i], 8'(fr[i] + 8'h05), 1'b1);
        go(1'b1, 1'b1, 16'd5, 16'h0080, 8'h05, n);
        done_q.push_back(n + 6);
        idle(8);
        chk("frac_drained", exp_q.size(), 0);

        // Zero-length burst
        v0 = vcnt;
        go(1'b1, 1'b1, 16'd0, 16'h0100, 8'h00, n);
        done_q.push_back(n + 1);
        chk("zero_busy_n", {31'd0, busy}, 32'd1);
        chk("zero_en_n", {31'd0, rom_en1}, 32'd0);
        idle(1);
        chk("zero_busy_n1", {31'd0, busy}, 32'd0);
        idle(3);
        chk("zero_valids", vcnt - v0, 0);

        // start+stop together in IDLE
        @(negedge clk);
        mode = 1'b0;
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_busy", {31'd0, busy}, 32'd0);
        idle(2);
        chk("startstop_idle", {31'd0, busy}, 32'd0);

        // start during RUN ignored, config immune, dual=0
        for (int i = 0; i < 4; i++) push(8'(3 * i), 8'(3 * i + 8'h10), 1'b0);
        go(1'b0, 1'b0, 16'd0, 16'h0300, 8'h10, n);
        done_q.push_back(n + 5);
        @(negedge clk);
        start = 1'b1;
        mode = 1'b1;
        dual = 1'b1;
        burst_len = 16'd1;
        incr = 16'h0700;
        offset = 8'h00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        idle(4);
        chk("ignore_drained", exp_q.size(), 0);
        chk("ignore_idle", {31'd0, busy}, 32'd0);

        // Async reset mid-burst
        for (int i = 0; i < 10; i++) push(8'(i), 8'(i), 1'b1);
        go(1'b1, 1'b1, 16'd10, 16'h0100, 8'h00, n);
        idle(2);
        #2 rst = 1'b1;
        #1;
        chk("rst_ctrl_zero", {24'd0, rom_en1, rom_en2, sample_valid, busy, done, 3'd0},
            32'd0);
        chk("rst_addr_zero", {16'd0, rom_addr1, rom_addr2}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        idle(4);
        chk("rst_no_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) push(8'(i), 8'(i + 8'h08), 1'b1);
        go(1'b1, 1'b1, 16'd3, 16'h0100, 8'h08, n);
        done_q.push_back(n + 4);
        idle(6);
        chk("replay_drained", exp_q.size(), 0);
        chk("done_all_seen", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
